// File: rtl/ctrl_pkg.sv
// Shared definitions for the ID/EX control stage: bundle layout, NOP value and
// the per-edge update-priority encoding.
package ctrl_pkg;

   localparam int unsigned CTRL_W = 8;

   localparam int unsigned ALUSRC_B   = 0;
   localparam int unsigned MEMTOREG_B = 1;
   localparam int unsigned REGWRITE_B = 2;
   localparam int unsigned MEMWRITE_B = 3;
   localparam int unsigned MEMREAD_B  = 4;
   localparam int unsigned BRANCH_B   = 5;
   localparam int unsigned ALUOP_LSB  = 6;
   localparam int unsigned ALUOP_MSB  = 7;

   localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

   // Highest encoding wins: hold > flush > stall > load.
   typedef enum logic [1:0] {
      UPD_LOAD  = 2'd0,
      UPD_STALL = 2'd1,
      UPD_FLUSH = 2'd2,
      UPD_HOLD  = 2'd3
   } upd_e;

   function automatic upd_e updSel(input logic hold, input logic flush, input logic stall);
      if (hold)       return UPD_HOLD;
      else if (flush) return UPD_FLUSH;
      else if (stall) return UPD_STALL;
      else            return UPD_LOAD;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats hold and increment.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   input  logic             clr_i,
   input  logic             hold_i,
   output logic [CNT_W-1:0] cnt_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         cnt_o <= '0;
      end else if (clr_i) begin
         cnt_o <= '0;
      end else if (!hold_i && inc_i && (cnt_o != CNT_MAX)) begin
         cnt_o <= cnt_o + CNT_W'(1);
      end
   end

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// ID->EX control register: squashes to NOP on stall/flush, holds on freeze,
// and counts inserted bubbles and flush kills.
module id_ex_ctrl_stage
   import ctrl_pkg::*;
#(
   parameter int unsigned       CTRL_W  = ctrl_pkg::CTRL_W,
   parameter logic [CTRL_W-1:0] NOP_VAL = {CTRL_W{1'b0}},
   parameter int unsigned       CNT_W   = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic              valid_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              hold_i,
   input  logic              cnt_clr_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic              valid_o,
   output logic              bubble_o,
   output logic [CNT_W-1:0]  bubble_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o
);

   upd_e              upd;
   logic [CTRL_W-1:0] ctrlNext;
   logic              validNext;
   logic              bubbleNext;

   assign upd = updSel(hold_i, flush_i, stall_i);

   // Next-state selection; an invalid load also drives NOP so enables never leak.
   always_comb begin
      ctrlNext   = ctrl_o;
      validNext  = valid_o;
      bubbleNext = bubble_o;
      case (upd)
         UPD_HOLD: ;
         UPD_FLUSH, UPD_STALL: begin
            ctrlNext   = NOP_VAL;
            validNext  = 1'b0;
            bubbleNext = 1'b1;
         end
         default: begin
            ctrlNext   = valid_i ? ctrl_i : NOP_VAL;
            validNext  = valid_i;
            bubbleNext = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         ctrl_o   <= NOP_VAL;
         valid_o  <= 1'b0;
         bubble_o <= 1'b0;
      end else begin
         ctrl_o   <= ctrlNext;
         valid_o  <= validNext;
         bubble_o <= bubbleNext;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) uBubbleCnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .inc_i  (upd == UPD_STALL),
      .clr_i  (cnt_clr_i),
      .hold_i (hold_i),
      .cnt_o  (bubble_cnt_o)
   );

   sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .inc_i  (upd == UPD_FLUSH),
      .clr_i  (cnt_clr_i),
      .hold_i (hold_i),
      .cnt_o  (flush_cnt_o)
   );

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Self-checking bench for id_ex_ctrl_stage: directed vector table, saturation
// sequence on a 4-bit-counter instance, and a randomised mix against a model.
module tb_id_ex_ctrl_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  ctrl;
   logic        valid, stall, flush, hold, clr;

   logic [7:0]  ctrlO;
   logic        validO, bubbleO;
   logic [15:0] bcntO, fcntO;

   logic [7:0]  sCtrlO;
   logic        sValidO, sBubbleO;
   logic [3:0]  sBcntO, sFcntO;

   int nChecks = 0;
   int nFail   = 0;

   always #5 clk = ~clk;

   id_ex_ctrl_stage dut (
      .clk_i(clk), .rst_i(rst), .ctrl_i(ctrl), .valid_i(valid), .stall_i(stall),
      .flush_i(flush), .hold_i(hold), .cnt_clr_i(clr), .ctrl_o(ctrlO),
      .valid_o(validO), .bubble_o(bubbleO), .bubble_cnt_o(bcntO), .flush_cnt_o(fcntO)
   );

   id_ex_ctrl_stage #(.CNT_W(4)) dutSat (
      .clk_i(clk), .rst_i(rst), .ctrl_i(ctrl), .valid_i(valid), .stall_i(stall),
      .flush_i(flush), .hold_i(hold), .cnt_clr_i(clr), .ctrl_o(sCtrlO),
      .valid_o(sValidO), .bubble_o(sBubbleO), .bubble_cnt_o(sBcntO), .flush_cnt_o(sFcntO)
   );

   typedef struct {
      logic        rst;
      logic [7:0]  ctrl;
      logic        valid, stall, flush, hold, clr;
      logic [7:0]  expCtrl;
      logic        expValid, expBubble;
      logic [15:0] expBcnt, expFcnt;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic addVec(input logic r, input logic [7:0] c, input logic v, input logic s,
                         input logic f, input logic h, input logic cl, input logic [7:0] eC,
                         input logic eV, input logic eB, input logic [15:0] eBc,
                         input logic [15:0] eFc);
      vec_t t;
      t.rst = r; t.ctrl = c; t.valid = v; t.stall = s; t.flush = f; t.hold = h; t.clr = cl;
      t.expCtrl = eC; t.expValid = eV; t.expBubble = eB; t.expBcnt = eBc; t.expFcnt = eFc;
      vecs.push_back(t);
   endtask

   task automatic drive(input logic r, input logic [7:0] c, input logic v, input logic s,
                        input logic f, input logic h, input logic cl);
      rst = r; ctrl = c; valid = v; stall = s; flush = f; hold = h; clr = cl;
      @(posedge clk);
      #1;
   endtask

   // Reference model state
   logic [7:0]  mCtrl;
   logic        mValid, mBubble;
   logic [15:0] mB16, mF16;
   logic [3:0]  mB4, mF4;

   task automatic modelStep();
      if (!rst) begin
         mCtrl = 8'h00; mValid = 1'b0; mBubble = 1'b0;
         mB16 = '0; mF16 = '0; mB4 = '0; mF4 = '0;
      end else begin
         if (clr) begin
            mB16 = '0; mF16 = '0; mB4 = '0; mF4 = '0;
         end else if (!hold && flush) begin
            if (mF16 != 16'hFFFF) mF16 = mF16 + 16'd1;
            if (mF4 != 4'hF) mF4 = mF4 + 4'd1;
         end else if (!hold && stall) begin
            if (mB16 != 16'hFFFF) mB16 = mB16 + 16'd1;
            if (mB4 != 4'hF) mB4 = mB4 + 4'd1;
         end
         if (!hold) begin
            if (flush || stall) begin
               mCtrl = 8'h00; mValid = 1'b0; mBubble = 1'b1;
            end else begin
               mCtrl = valid ? ctrl : 8'h00; mValid = valid; mBubble = 1'b0;
            end
         end
      end
   endtask

   initial begin
      // rst ctrl  v  s  f  h  clr | ctrl  v  b  bcnt fcnt
      addVec(0, 8'hFF, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
      addVec(0, 8'hFF, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
      addVec(1, 8'hFF, 1, 0, 0, 0, 0, 8'hFF, 1, 0, 0, 0);
      addVec(1, 8'h2C, 1, 1, 0, 0, 0, 8'h00, 0, 1, 1, 0);
      addVec(1, 8'h2C, 1, 1, 0, 0, 0, 8'h00, 0, 1, 2, 0);
      addVec(1, 8'h2C, 1, 1, 0, 0, 0, 8'h00, 0, 1, 3, 0);
      addVec(1, 8'h2C, 1, 0, 0, 0, 0, 8'h2C, 1, 0, 3, 0);
      addVec(1, 8'h55, 1, 1, 1, 0, 0, 8'h00, 0, 1, 3, 1);
      addVec(1, 8'h13, 1, 0, 0, 0, 0, 8'h13, 1, 0, 3, 1);
      for (int i = 0; i < 4; i++)
         addVec(1, 8'hA0, 1, 0, 1, 1, 0, 8'h13, 1, 0, 3, 1);
      addVec(1, 8'hA0, 1, 0, 0, 0, 0, 8'hA0, 1, 0, 3, 1);
      addVec(1, 8'h7E, 0, 0, 0, 0, 0, 8'h00, 0, 0, 3, 1);
      addVec(1, 8'h7E, 1, 1, 0, 1, 1, 8'h00, 0, 0, 0, 0);
      addVec(1, 8'h42, 0, 0, 1, 0, 0, 8'h00, 0, 1, 0, 1);
      addVec(1, 8'h81, 1, 0, 0, 0, 0, 8'h81, 1, 0, 0, 1);
      addVec(1, 8'h99, 1, 1, 0, 0, 0, 8'h00, 0, 1, 1, 1);
      addVec(0, 8'h99, 1, 1, 0, 1, 0, 8'h00, 0, 0, 0, 0);

      rst = 1'b0; ctrl = '0; valid = 0; stall = 0; flush = 0; hold = 0; clr = 0;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].ctrl, vecs[i].valid, vecs[i].stall,
               vecs[i].flush, vecs[i].hold, vecs[i].clr);
         chk($sformatf("vec%0d ctrl", i),   32'(ctrlO),   32'(vecs[i].expCtrl));
         chk($sformatf("vec%0d valid", i),  32'(validO),  32'(vecs[i].expValid));
         chk($sformatf("vec%0d bubble", i), 32'(bubbleO), 32'(vecs[i].expBubble));
         chk($sformatf("vec%0d bcnt", i),   32'(bcntO),   32'(vecs[i].expBcnt));
         chk($sformatf("vec%0d fcnt", i),   32'(fcntO),   32'(vecs[i].expFcnt));
      end

      // Saturation on the 4-bit instance, then clear beating a same-cycle stall
      drive(0, 8'h00, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) drive(1, 8'h11, 1, 1, 0, 0, 0);
      chk("sat bcnt4", 32'(sBcntO), 32'd15);
      chk("sat bcnt16", 32'(bcntO), 32'd20);
      chk("sat fcnt4", 32'(sFcntO), 32'd0);
      drive(1, 8'h11, 1, 1, 0, 0, 1);
      chk("clr bcnt4", 32'(sBcntO), 32'd0);
      chk("clr bcnt16", 32'(bcntO), 32'd0);
      chk("clr bubble", 32'(sBubbleO), 32'd1);
      drive(1, 8'h11, 1, 1, 0, 0, 0);
      chk("post clr bcnt4", 32'(sBcntO), 32'd1);
      for (int i = 0; i < 17; i++) drive(1, 8'h22, 1, 0, 1, 0, 0);
      chk("sat fcnt4", 32'(sFcntO), 32'd15);
      chk("sat fcnt16", 32'(fcntO), 32'd17);

      // Random mix against the model
      rst = 1'b0;
      modelStep();
      drive(0, 8'h00, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10000; i++) begin
         rst   = ($urandom_range(0, 63) != 0);
         ctrl  = 8'($urandom);
         valid = ($urandom_range(0, 3) != 0);
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 7) == 0);
         hold  = ($urandom_range(0, 3) == 0);
         clr   = ($urandom_range(0, 31) == 0);
         modelStep();
         @(posedge clk);
         #1;
         chk("rnd ctrl",   32'(ctrlO),   32'(mCtrl));
         chk("rnd valid",  32'(validO),  32'(mValid));
         chk("rnd bubble", 32'(bubbleO), 32'(mBubble));
         chk("rnd bcnt",   32'(bcntO),   32'(mB16));
         chk("rnd fcnt",   32'(fcntO),   32'(mF16));
         chk("rnd bcnt4",  32'(sBcntO),  32'(mB4));
         chk("rnd fcnt4",  32'(sFcntO),  32'(mF4));
         if (!validO) chk("rnd nop when invalid", 32'(ctrlO), 32'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
